// File: rtl/seq_detect_param.sv
// Parameterised serial sequence detector with runtime-loadable pattern.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   datain, din_valid   serial bit and its qualifier
//   cfg_load            strobe latching cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern         pattern, bit [len-1] received first, bit [0] last
//   cfg_len             active pattern length (0 disables, >MAX_LEN clamps)
//   cfg_overlap         1 = overlapping matches, 0 = non-overlapping
//   cnt_clear           clears match_count
//   dataout             combinational (Mealy) match pulse
//   match_count         saturating match counter
//   fill                number of fresh history bits held (0..MAX_LEN)
module seq_detect_param #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned LEN_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               datain,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clear,
  output logic               dataout,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill
);

  localparam int unsigned LW1 = LEN_W + 1;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len_clamped;
  logic               fill_ok;
  logic               match;

  // Match evaluation: newest len bits (history tail + current bit) vs pattern
  always_comb begin
    window = {hist_q[MAX_LEN-2:0], datain};
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (i < int'(len_q));
    end
    // fill >= len-1 written as fill+1 >= len to avoid underflow at len = 0
    fill_ok = (LW1'(fill_q) + LW1'(1)) >= LW1'(len_q);
    match   = din_valid && !cfg_load && !reset && (len_q != '0) && fill_ok &&
              (((window ^ pat_q) & mask) == '0);
    len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
  end

  // Next-state logic; cfg_load outranks din_valid and cnt_clear
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = len_clamped;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else begin
      if (din_valid) begin
        hist_d = {hist_q[MAX_LEN-2:0], datain};
        // Non-overlap: a match consumes its bits, so restart the fresh-bit count
        if (match && !ovl_q) begin
          fill_d = '0;
        end else if (fill_q != LEN_W'(MAX_LEN)) begin
          fill_d = fill_q + LEN_W'(1);
        end
      end
      if (cnt_clear) begin
        cnt_d = '0;
      end else if (match && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset to the default 11101 / len 5 config
  always_ff @(posedge clock) begin
    if (reset) begin
      pat_q  <= MAX_LEN'(5'b11101);
      len_q  <= LEN_W'(5);
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dataout     = match;
  assign match_count = cnt_q;
  assign fill        = fill_q;

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (SHALL be >= 5).
REQ-002 Parameter CNT_W, default 16, width of match counter.
REQ-003 Parameter LEN_W, default 4, width of length field (SHALL hold MAX_LEN).
REQ-004 Port clock  input  1  rising-edge clock; all state updates on posedge clock.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port datain  input  1  serial data bit.
REQ-007 Port din_valid  input  1  datain is sampled only when high.
REQ-008 Port cfg_load  input  1  one-cycle strobe; latch cfg_pattern/cfg_len/cfg_overlap.
REQ-009 Port cfg_pattern  input  MAX_LEN  pattern; bit [len-1] first received, bit [0] last.
REQ-010 Port cfg_len  input  LEN_W  active pattern length.
REQ-011 Port cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-012 Port cnt_clear  input  1  clears match_count.
REQ-013 Port dataout  output  1  Mealy match pulse.
REQ-014 Port match_count  output  CNT_W  saturating count of matches.
REQ-015 Port fill  output  LEN_W  number of valid history bits held (0..MAX_LEN).

Function
REQ-016 Active config registers (pat, len, ovl) SHALL update only on reset or cfg_load.
REQ-017 Effective length: cfg_len = 0 -> detector disabled (dataout never asserts); cfg_len > MAX_LEN -> clamped to MAX_LEN at load.
REQ-018 History: MAX_LEN-bit shift register; on din_valid, shift left, insert datain at bit 0; fill increments, saturating at MAX_LEN.
REQ-019 dataout SHALL be combinational (Mealy): high iff din_valid, len != 0, fill >= len-1, and {history[len-2:0], datain} == pat[len-1:0] (len = 1 compares datain alone).
REQ-020 dataout SHALL be low whenever din_valid = 0, cfg_load = 1, or reset = 1.
REQ-021 Overlap mode (ovl = 1): after a match, history and fill continue normally; the next match may reuse trailing bits.
REQ-022 Non-overlap mode (ovl = 0): on a match cycle, fill SHALL be set to 0 (history contents don't-care); next match requires len fresh bits.
REQ-023 match_count SHALL increment by 1 on each dataout = 1 cycle, saturating at all-ones.
REQ-024 cnt_clear and a match in the same cycle: count SHALL become 0 (clear wins).
REQ-025 cfg_load: latch config, clear history and fill to 0, clear match_count; datain that cycle SHALL be ignored.
REQ-026 cfg_load has priority over din_valid; reset has priority over all.
REQ-027 Patterns SHALL be detected back-to-back with no dead cycles; din_valid gaps SHALL NOT break a partial match.

Reset
REQ-028 On reset: pat = 5'b11101 zero-extended, len = 5, ovl = 1, history = 0, fill = 0, match_count = 0, dataout = 0.
REQ-029 Reset asserted mid-stream SHALL discard any partial match; first match after release requires len new bits.

Verification
REQ-030 Default config, din_valid = 1, stream 1,1,1,0,1,1,1,0,1 -> dataout high at bits 5 and 9 only; match_count = 2.
REQ-031 cfg_load pattern 11101, len 5, ovl 0, same stream -> dataout high at bit 5 only; match_count = 1.
REQ-032 Default config, stream 1,1,1,1,1,0,1 -> single match on bit 7; stream 1,1,1,0 then din_valid low 3 cycles then 1 -> match on the final bit.
REQ-033 cfg_load len 1, pattern 1, ovl 1, stream 1,0,1,1 -> dataout on bits 1,3,4; cfg_len = 0 -> no matches on any stream.
REQ-034 CNT_W = 2, default config, repeating 11101 stream -> count 1,2,3,3 (saturates); cnt_clear with simultaneous match -> count 0.
REQ-035 Reset asserted after stream 1,1,1,0 then released, stream 1 -> no match; then 1,1,1,0,1 -> match on last bit.
